// File: rtl/sema_fifo.sv
//==============================================================================
// Module      : sema_fifo
// Description : Bidirectional semaphore mailbox built from two independent FIFO
//               channels (A->B and B->A), each with a sticky overflow flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sema_fifo_chan #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    input  logic              i_ovf_clr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_ovf
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    assign o_valid = (r_state != ST_EMPTY);
    assign o_empty = (r_state == ST_EMPTY);
    assign o_full  = (r_state == ST_FULL);
    assign o_data  = r_mem[r_rptr];
    assign o_ovf   = r_ovf;

    // A pop frees a slot on the same edge, so a write at full is still accepted.
    assign w_pop  = o_valid & i_ready;
    assign w_push = i_write & (~o_full | w_pop);
    assign w_drop = i_write & o_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
            if (w_drop)         r_ovf <= 1'b1;
            else if (i_ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) w_state_nxt = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (w_push && !w_pop && (r_count == CW'(DEPTH - 1)))
                    w_state_nxt = ST_FULL;
                else if (w_pop && !w_push && (r_count == CW'(1)))
                    w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_pop && !w_push) w_state_nxt = ST_PARTIAL;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end
endmodule

module sema_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_s,
    input  logic              rstn_s,
    input  logic              sema_write_o_s_A,
    input  logic [DATA_W-1:0] sema_data_o_s_A,
    output logic              sema_is_empty_i_s_A,
    output logic              sema_is_full_i_s_A,
    output logic              sema_ovf_i_s_A,
    input  logic              sema_ovf_clr_o_s_A,
    output logic [DATA_W-1:0] sema_data_i_s_B,
    output logic              sema_valid_i_s_B,
    input  logic              sema_ready_o_s_B,
    input  logic              sema_write_o_s_B,
    input  logic [DATA_W-1:0] sema_data_o_s_B,
    output logic              sema_is_empty_i_s_B,
    output logic              sema_is_full_i_s_B,
    output logic              sema_ovf_i_s_B,
    input  logic              sema_ovf_clr_o_s_B,
    output logic [DATA_W-1:0] sema_data_i_s_A,
    output logic              sema_valid_i_s_A,
    input  logic              sema_ready_o_s_A
);
    sema_fifo_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_chan_a2b (
        .clk       (clk_s),
        .rst_n     (rstn_s),
        .i_write   (sema_write_o_s_A),
        .i_data    (sema_data_o_s_A),
        .i_ready   (sema_ready_o_s_B),
        .i_ovf_clr (sema_ovf_clr_o_s_A),
        .o_data    (sema_data_i_s_B),
        .o_valid   (sema_valid_i_s_B),
        .o_empty   (sema_is_empty_i_s_A),
        .o_full    (sema_is_full_i_s_A),
        .o_ovf     (sema_ovf_i_s_A)
    );

    sema_fifo_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_chan_b2a (
        .clk       (clk_s),
        .rst_n     (rstn_s),
        .i_write   (sema_write_o_s_B),
        .i_data    (sema_data_o_s_B),
        .i_ready   (sema_ready_o_s_A),
        .i_ovf_clr (sema_ovf_clr_o_s_B),
        .o_data    (sema_data_i_s_A),
        .o_valid   (sema_valid_i_s_A),
        .o_empty   (sema_is_empty_i_s_B),
        .o_full    (sema_is_full_i_s_B),
        .o_ovf     (sema_ovf_i_s_B)
    );
endmodule

`default_nettype wire

// File: tb/tb_sema_fifo.sv
//==============================================================================
// Module      : tb_sema_fifo
// Description : Directed self-checking bench for sema_fifo (DATA_W=8, DEPTH=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sema_fifo;
    logic       clk_s = 1'b0;
    logic       rstn_s;
    logic       wr_a, wr_b, rdy_a, rdy_b, clr_a, clr_b;
    logic [7:0] din_a, din_b;
    logic [7:0] dout_a, dout_b;
    logic       empty_a, full_a, ovf_a, valid_b;
    logic       empty_b, full_b, ovf_b, valid_a;
    int         checks = 0;
    int         errors = 0;

    always #5 clk_s = ~clk_s;

    sema_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clk_s               (clk_s),
        .rstn_s              (rstn_s),
        .sema_write_o_s_A    (wr_a),
        .sema_data_o_s_A     (din_a),
        .sema_is_empty_i_s_A (empty_a),
        .sema_is_full_i_s_A  (full_a),
        .sema_ovf_i_s_A      (ovf_a),
        .sema_ovf_clr_o_s_A  (clr_a),
        .sema_data_i_s_B     (dout_b),
        .sema_valid_i_s_B    (valid_b),
        .sema_ready_o_s_B    (rdy_b),
        .sema_write_o_s_B    (wr_b),
        .sema_data_o_s_B     (din_b),
        .sema_is_empty_i_s_B (empty_b),
        .sema_is_full_i_s_B  (full_b),
        .sema_ovf_i_s_B      (ovf_b),
        .sema_ovf_clr_o_s_B  (clr_b),
        .sema_data_i_s_A     (dout_a),
        .sema_valid_i_s_A    (valid_a),
        .sema_ready_o_s_A    (rdy_a)
    );

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic idle_inputs();
        wr_a = 0; wr_b = 0; rdy_a = 0; rdy_b = 0; clr_a = 0; clr_b = 0;
        din_a = 8'h00; din_b = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn_s = 0;
        tick();
        tick();
        rstn_s = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn_s = 1;
        tick();
        #2 rstn_s = 0;
        #1;
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %b exp 0", valid_b); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b exp 0", valid_a); end
        checks++; if ({empty_a, full_a, ovf_a} !== 3'b100) begin errors++; $display("FAIL reset_flags_a got %b exp 100", {empty_a, full_a, ovf_a}); end
        checks++; if ({empty_b, full_b, ovf_b} !== 3'b100) begin errors++; $display("FAIL reset_flags_b got %b exp 100", {empty_b, full_b, ovf_b}); end
        tick();
        rstn_s = 1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        wr_a = 1; din_a = 8'hA5;
        tick();
        wr_a = 0;
        checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", valid_b); end
        checks++; if (dout_b !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", dout_b); end
        checks++; if (empty_a !== 1'b0) begin errors++; $display("FAIL single_notempty got %b exp 0", empty_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL single_other_chan got %b exp 0", valid_a); end
        rdy_b = 1;
        tick();
        rdy_b = 0;
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL single_popped got %b exp 0", valid_b); end
        checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL single_empty got %b exp 1", empty_a); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            wr_a = 1; din_a = 8'(k);
            tick();
            if (k == 3) begin
                checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL ovf_notfull3 got %b exp 0", full_a); end
            end
            if (k == 4) begin
                checks++; if (full_a !== 1'b1) begin errors++; $display("FAIL ovf_full4 got %b exp 1", full_a); end
                checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ovf_a); end
            end
        end
        wr_a = 0;
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_a); end
        checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_other_chan got %b exp 0", ovf_b); end
        rdy_b = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({valid_b, dout_b} !== {1'b1, 8'(i + 1)}) begin errors++; $display("FAIL ovf_drain%0d got v%b %h exp v1 %h", i, valid_b, dout_b, 8'(i + 1)); end
            tick();
        end
        rdy_b = 0;
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", valid_b); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_a); end
        clr_a = 1;
        tick();
        clr_a = 0;
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", ovf_a); end
        // Same drop on B->A to confirm that channel's overflow path too.
        for (int k = 0; k < 5; k++) begin
            wr_b = 1; din_b = 8'(8'hE0 + k);
            tick();
        end
        wr_b = 0;
        checks++; if ({full_b, ovf_b, ovf_a} !== 3'b110) begin errors++; $display("FAIL ovf_b_flags got %b exp 110", {full_b, ovf_b, ovf_a}); end
        checks++; if (dout_a !== 8'hE0) begin errors++; $display("FAIL ovf_b_head got %h exp e0", dout_a); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h41; exp_q[1] = 8'h42; exp_q[2] = 8'h43; exp_q[3] = 8'h10;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wr_a = 1; din_a = 8'(8'h40 + k);
            tick();
        end
        wr_a = 1; din_a = 8'h10; rdy_b = 1;
        tick();
        wr_a = 0; rdy_b = 0;
        checks++; if (full_a !== 1'b1) begin errors++; $display("FAIL pp_full got %b exp 1", full_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL pp_ovf got %b exp 0", ovf_a); end
        rdy_b = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({valid_b, dout_b} !== {1'b1, exp_q[i]}) begin errors++; $display("FAIL pp_drain%0d got v%b %h exp v1 %h", i, valid_b, dout_b, exp_q[i]); end
            tick();
        end
        rdy_b = 0;
        checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL pp_empty got %b exp 1", empty_a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx_b [$];
        logic [7:0] rx_a [$];
        int         sent_a = 0;
        int         sent_b = 0;
        int         cyc = 0;
        do_reset();
        while ((rx_a.size() < 8 || rx_b.size() < 8) && cyc < 200) begin
            rdy_b = (cyc % 2) == 0;
            rdy_a = (cyc % 3) != 1;
            wr_a = (sent_a < 8) && !full_a; din_a = 8'(8'h20 + sent_a);
            wr_b = (sent_b < 8) && !full_b; din_b = 8'(8'h30 + sent_b);
            if (wr_a) sent_a++;
            if (wr_b) sent_b++;
            if (valid_b && rdy_b) rx_b.push_back(dout_b);
            if (valid_a && rdy_a) rx_a.push_back(dout_a);
            tick();
            cyc++;
        end
        idle_inputs();
        checks++; if (cyc >= 200) begin errors++; $display("FAIL b2b_timeout got %0d/%0d exp 8/8", rx_b.size(), rx_a.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (i >= rx_b.size() || rx_b[i] !== 8'(8'h20 + i)) begin errors++; $display("FAIL b2b_a2b%0d got %h exp %h", i, (i < rx_b.size()) ? rx_b[i] : 8'hxx, 8'(8'h20 + i)); end
            checks++; if (i >= rx_a.size() || rx_a[i] !== 8'(8'h30 + i)) begin errors++; $display("FAIL b2b_b2a%0d got %h exp %h", i, (i < rx_a.size()) ? rx_a[i] : 8'hxx, 8'(8'h30 + i)); end
        end
        checks++; if ({ovf_a, ovf_b, empty_a, empty_b} !== 4'b0011) begin errors++; $display("FAIL b2b_end got %b exp 0011", {ovf_a, ovf_b, empty_a, empty_b}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr_a = 1; din_a = 8'(8'h50 + k);
            tick();
        end
        wr_a = 0;
        checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", valid_b); end
        #2 rstn_s = 0;
        #1;
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", valid_b); end
        checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", empty_a); end
        #2 rstn_s = 1;
        wr_a = 1; din_a = 8'h77;
        tick();
        wr_a = 0;
        checks++; if ({valid_b, dout_b} !== {1'b1, 8'h77}) begin errors++; $display("FAIL rmid_first got v%b %h exp v1 77", valid_b, dout_b); end
        rdy_b = 1;
        tick();
        rdy_b = 0;
        checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL rmid_only got %b exp 1", empty_a); end
    endtask

    task automatic test_drop_clr();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wr_a = 1; din_a = 8'(8'h60 + k);
            tick();
        end
        wr_a = 1; din_a = 8'h99; clr_a = 1;
        tick();
        wr_a = 0; clr_a = 0;
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL dclr_setwins got %b exp 1", ovf_a); end
        checks++; if (dout_b !== 8'h60) begin errors++; $display("FAIL dclr_head got %h exp 60", dout_b); end
        clr_a = 1;
        tick();
        clr_a = 0;
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL dclr_clear got %b exp 0", ovf_a); end
    endtask

    initial begin
        idle_inputs();
        rstn_s = 0;
        test_reset();
        test_single();
        test_overflow();
        test_full_pushpop();
        test_back_to_back();
        test_reset_mid();
        test_drop_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
